barrel_pool: RTL and testbench
==============================

# barrel_pool

Parametrised barrel engine that replaces the fixed set of five horizontal plus five vertical barrel instances and their per-group controllers with one N-slot pool. It spawns barrels on a timer or on a remote (UART) key, moves each slot in zig-zag (rolling) or vertical (falling) mode, retires slots at the playfield bottom and flags donkey–barrel collisions. It sits between the game-control logic (`start_game`, `animation`, `xpos_kong`, donkey position) and `draw_barrel`, which consumes `active`/`xpos`/`ypos`.

## Interface
- BARRELS, 10: number of slots, 1..16.
- DELAY_CYCLES, 162_500_000: auto-spawn period in clk cycles.
- STEP_CYCLES, 650_000: clk cycles per motion step.
- STEP_PX, 4: pixels moved per step.
- X_MIN, 0 / X_MAX, 976: horizontal turn-around limits.
- DROP_PX, 96: vertical drop at each turn-around in roll mode.
- Y_MAX, 704: retire threshold.
- SPAWN_X, 160 / SPAWN_Y, 128: roll-mode spawn point.
- BARREL_SIZE, 32 / DONKEY_W, 48 / DONKEY_H, 64: collision box sizes.
- clk  in  1  65 MHz pixel clock.
- rst  in  1  synchronous, active-high reset.
- start_game  in  1  game running; low clears the pool.
- animation  in  1  intro animation in progress; spawning and motion frozen while high.
- key_fall  in  1  level-held remote key; its rising edge requests a vertical spawn.
- xpos_kong  in  11  x coordinate for vertical spawns.
- xpos_donkey, ypos_donkey  in  11 each  donkey top-left corner.
- active  out  BARRELS  per-slot busy flag.
- xpos, ypos  out  [BARRELS-1:0][11]  per-slot top-left corner.
- done  out  BARRELS  one-cycle pulse when a slot retires.
- overflow  out  1  one-cycle pulse when a spawn is dropped because no slot is free.
- hit  out  1  registered collision flag.

## Operation
- All outputs reset to 0, and all counters and slots clear.
- The same clearing occurs on any cycle with `start_game`=0.
- Run condition: `start_game`=1 and `animation`=0. While not running, timers hold and slots freeze without clearing.
- Spawn sources:
  - Auto: the delay counter counts while running and issues a roll spawn when it reaches DELAY_CYCLES-1, then wraps to 0.
  - Key: a rising edge of `key_fall` issues a fall spawn. The edge detector is registered.
  - If both occur in the same cycle, the fall spawn wins and the auto spawn is dropped. `overflow` does not pulse for that drop.
- Slot allocation: the lowest-index slot with `active`=0 is chosen. If no slot is free, the spawn is dropped and `overflow` pulses.
- Slot states are IDLE, ROLL_R, ROLL_L and FALL.
  - IDLE→ROLL_R on a roll spawn. Position is set to (SPAWN_X, SPAWN_Y).
  - IDLE→FALL on a fall spawn. Position is set to (`xpos_kong` sampled at spawn, 0).
- Step tick: the step counter pulses every STEP_CYCLES cycles while running. Every non-IDLE slot updates on the tick.
  - ROLL_R: if x+STEP_PX ≥ X_MAX, then x←X_MAX, y←y+DROP_PX, go to ROLL_L. Otherwise x←x+STEP_PX.
  - ROLL_L: if x ≤ X_MIN+STEP_PX, then x←X_MIN, y←y+DROP_PX, go to ROLL_R. Otherwise x←x−STEP_PX.
  - FALL: y←y+STEP_PX.
- Retire: a non-IDLE slot with y ≥ Y_MAX after its update goes to IDLE on the next tick-free cycle. On that cycle `done[i]` pulses and `active[i]` goes to 0. x and y hold their last values.
- Arithmetic is 12-bit internally, so there is no wrap. Positions saturate at 2047 before truncation to 11 bits.
- Collision: `hit` is the OR over active slots of box overlap. Boxes are [x, x+BARREL_SIZE) × [y, y+BARREL_SIZE) against [xd, xd+DONKEY_W) × [yd, yd+DONKEY_H). Comparisons are strict and edge-touching does not hit.

## Timing
- Spawn: a request at cycle t gives `active`=1 with spawn coordinates at t+1.
- Key: a rising edge seen at t issues its spawn at t+1 (edge register) and is visible at t+2.
- Motion: the tick at cycle t updates position at t+1.
- Retire: `done` pulses exactly one cycle, coincident with `active` falling.
- Same-cycle retire and spawn: the retiring slot is still treated as occupied. The spawn takes the next free slot, or overflows.
- `hit` lags the positions by 1 cycle and stays high while overlap persists.
- A reset or `start_game` drop mid-motion clears everything on the next edge. Any pending edge-detect state is also cleared.

## Test plan
- Parameters for all scenarios: BARRELS=2, DELAY_CYCLES=100, STEP_CYCLES=4, STEP_PX=8, X_MAX=200, Y_MAX=300, DROP_PX=96, SPAWN=(160,128).
- Auto spawn: hold running for 100 cycles → slot0 active with (160,128) at cycle 100, and slot1 spawns at cycle 200.
- Turn-around: after 5 steps slot0 reaches x=200 → y=224 and direction left, so the next step gives x=192.
- Retire: on the second drop y=320 ≥ 300 → `done[0]` pulses once and `active[0]`=0. The third auto spawn then reuses slot0.
- Overflow: both slots active when an auto spawn arrives → `overflow`=1 for one cycle and `active` stays 2'b11.
- Key priority: `key_fall` rises with `xpos_kong`=512 in the same cycle the auto timer expires → one FALL slot at (512,0) and the auto spawn is dropped without `overflow`.
- Collision and clear: donkey at (176,112) against a barrel at (160,128) → `hit`=1 one cycle later. Donkey at (192,128) → `hit`=0 (edge-touching). Dropping `start_game` → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/barrel_pool_if.sv
// Signal bundle between game control, the barrel pool and the barrel renderer.
// master drives the game-side inputs; slave is the pool itself.
interface barrel_pool_if #(
    parameter int unsigned BARRELS = 10
) ();
    logic                     start_game;
    logic                     animation;
    logic                     key_fall;
    logic [10:0]              xpos_kong;
    logic [10:0]              xpos_donkey;
    logic [10:0]              ypos_donkey;
    logic [BARRELS-1:0]       active;
    logic [BARRELS-1:0][10:0] xpos;
    logic [BARRELS-1:0][10:0] ypos;
    logic [BARRELS-1:0]       done;
    logic                     overflow;
    logic                     hit;

    modport master (
        output start_game, animation, key_fall, xpos_kong, xpos_donkey, ypos_donkey,
        input  active, xpos, ypos, done, overflow, hit
    );

    modport slave (
        input  start_game, animation, key_fall, xpos_kong, xpos_donkey, ypos_donkey,
        output active, xpos, ypos, done, overflow, hit
    );
endinterface

// File: rtl/barrel_pool.sv
// N-slot barrel engine: timer/key spawning, roll and fall motion, retirement at the
// playfield bottom and a registered donkey-barrel collision flag.
module barrel_pool #(
    parameter int unsigned BARRELS      = 10,
    parameter int unsigned DELAY_CYCLES = 162_500_000,
    parameter int unsigned STEP_CYCLES  = 650_000,
    parameter int unsigned STEP_PX      = 4,
    parameter int unsigned X_MIN        = 0,
    parameter int unsigned X_MAX        = 976,
    parameter int unsigned DROP_PX      = 96,
    parameter int unsigned Y_MAX        = 704,
    parameter int unsigned SPAWN_X      = 160,
    parameter int unsigned SPAWN_Y      = 128,
    parameter int unsigned BARREL_SIZE  = 32,
    parameter int unsigned DONKEY_W     = 48,
    parameter int unsigned DONKEY_H     = 64
) (
    input logic          clk,
    input logic          rst,
    barrel_pool_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ROLL_R = 2'd1;
    localparam logic [1:0] ROLL_L = 2'd2;
    localparam logic [1:0] FALL   = 2'd3;

    localparam int unsigned DCW = $clog2(DELAY_CYCLES) + 1;
    localparam int unsigned SCW = $clog2(STEP_CYCLES) + 1;

    localparam logic [11:0] STEP12 = 12'(STEP_PX);
    localparam logic [11:0] DROP12 = 12'(DROP_PX);
    localparam logic [11:0] XMIN12 = 12'(X_MIN);
    localparam logic [11:0] XMAX12 = 12'(X_MAX);
    localparam logic [11:0] YMAX12 = 12'(Y_MAX);
    localparam logic [11:0] BS12   = 12'(BARREL_SIZE);
    localparam logic [11:0] DW12   = 12'(DONKEY_W);
    localparam logic [11:0] DH12   = 12'(DONKEY_H);
    localparam logic [10:0] STEP11 = 11'(STEP_PX);
    localparam logic [10:0] XMIN11 = 11'(X_MIN);
    localparam logic [10:0] XMAX11 = 11'(X_MAX);
    localparam logic [10:0] SPX11  = 11'(SPAWN_X);
    localparam logic [10:0] SPY11  = 11'(SPAWN_Y);

    logic                     run, auto_req, tick;
    logic                     spawn_any, spawn_fall, found, overflow_d;
    logic [DCW-1:0]           delay_cnt;
    logic [SCW-1:0]           step_cnt;
    logic                     key_q, fall_req_q;
    logic [BARRELS-1:0][1:0]  state_q, state_d;
    logic [BARRELS-1:0][10:0] x_q, x_d, y_q, y_d;
    logic [BARRELS-1:0]       active, grant, overlap, done_d, done_q;
    logic                     overflow_q, hit_q;
    logic [11:0]              dx, dy;

    // 12-bit intermediate results clamp to the largest 11-bit coordinate.
    function automatic logic [10:0] sat11(input logic [11:0] v);
        return v[11] ? 11'h7ff : v[10:0];
    endfunction

    assign run        = bus.start_game && !bus.animation;
    assign auto_req   = run && (delay_cnt == DCW'(DELAY_CYCLES - 1));
    assign tick       = run && (step_cnt == SCW'(STEP_CYCLES - 1));
    assign spawn_fall = run && fall_req_q;
    assign spawn_any  = spawn_fall || auto_req;
    assign overflow_d = spawn_any && !found;
    assign dx         = {1'b0, bus.xpos_donkey};
    assign dy         = {1'b0, bus.ypos_donkey};

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < BARRELS; i++) begin
            active[i]  = (state_q[i] != IDLE);
            overlap[i] = ({1'b0, x_q[i]} < dx + DW12) && (dx < {1'b0, x_q[i]} + BS12) &&
                         ({1'b0, y_q[i]} < dy + DH12) && (dy < {1'b0, y_q[i]} + BS12);
            if (!active[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        done_d  = '0;
        for (int i = 0; i < BARRELS; i++) begin
            if (spawn_any && grant[i]) begin
                state_d[i] = spawn_fall ? FALL : ROLL_R;
                x_d[i]     = spawn_fall ? bus.xpos_kong : SPX11;
                y_d[i]     = spawn_fall ? 11'd0 : SPY11;
            end else if (run && active[i]) begin
                if (tick) begin
                    case (state_q[i])
                        ROLL_R: begin
                            if ({1'b0, x_q[i]} + STEP12 >= XMAX12) begin
                                x_d[i]     = XMAX11;
                                y_d[i]     = sat11({1'b0, y_q[i]} + DROP12);
                                state_d[i] = ROLL_L;
                            end else begin
                                x_d[i] = sat11({1'b0, x_q[i]} + STEP12);
                            end
                        end
                        ROLL_L: begin
                            if ({1'b0, x_q[i]} <= XMIN12 + STEP12) begin
                                x_d[i]     = XMIN11;
                                y_d[i]     = sat11({1'b0, y_q[i]} + DROP12);
                                state_d[i] = ROLL_R;
                            end else begin
                                x_d[i] = x_q[i] - STEP11;
                            end
                        end
                        default: y_d[i] = sat11({1'b0, y_q[i]} + STEP12);
                    endcase
                end else if ({1'b0, y_q[i]} >= YMAX12) begin
                    // Retirement waits for a tick-free cycle so it never races a move.
                    state_d[i] = IDLE;
                    done_d[i]  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !bus.start_game) begin
            delay_cnt  <= '0;
            step_cnt   <= '0;
            key_q      <= 1'b0;
            fall_req_q <= 1'b0;
            state_q    <= '0;
            x_q        <= '0;
            y_q        <= '0;
            done_q     <= '0;
            overflow_q <= 1'b0;
            hit_q      <= 1'b0;
        end else begin
            key_q      <= bus.key_fall;
            fall_req_q <= bus.key_fall && !key_q;
            if (run) begin
                delay_cnt <= auto_req ? '0 : delay_cnt + DCW'(1);
                step_cnt  <= tick ? '0 : step_cnt + SCW'(1);
            end
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            hit_q      <= |(active & overlap);
        end
    end

    assign bus.active   = active;
    assign bus.xpos     = x_q;
    assign bus.ypos     = y_q;
    assign bus.done     = done_q;
    assign bus.overflow = overflow_q;
    assign bus.hit      = hit_q;
endmodule

// File: tb/tb_barrel_pool.sv
// Self-checking bench for barrel_pool: directed sequences, a collision vector table and
// randomized traffic compared against a slot-list reference model.
module tb_barrel_pool;
    localparam int unsigned NB     = 2;
    localparam int unsigned DELAY  = 100;
    localparam int unsigned STEPC  = 4;
    localparam int unsigned STEPPX = 8;
    localparam int unsigned XMAX   = 200;
    localparam int unsigned YMAX   = 300;
    localparam int unsigned DROP   = 96;
    localparam int unsigned SX     = 160;
    localparam int unsigned SY     = 128;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    barrel_pool_if #(.BARRELS(NB)) bus ();

    barrel_pool #(
        .BARRELS(NB), .DELAY_CYCLES(DELAY), .STEP_CYCLES(STEPC), .STEP_PX(STEPPX),
        .X_MIN(0), .X_MAX(XMAX), .DROP_PX(DROP), .Y_MAX(YMAX), .SPAWN_X(SX), .SPAWN_Y(SY),
        .BARREL_SIZE(32), .DONKEY_W(48), .DONKEY_H(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: list of barrels, each either free or moving right/left/down.
    typedef struct {
        bit busy;
        int dir;  // +1 rolling right, -1 rolling left, 0 falling
        int x;
        int y;
    } slot_t;

    slot_t       ms [NB];
    int          m_delay, m_step;
    bit          m_prev_key, m_pend, m_ovf, m_hit;
    bit [NB-1:0] m_done;

    function automatic int sat(input int v);
        return (v > 2047) ? 2047 : v;
    endfunction

    function automatic bit boxes_meet(input int bx, input int by, input int px, input int py);
        return (bx < px + 48) && (px < bx + 32) && (by < py + 64) && (py < by + 32);
    endfunction

    task automatic model_update();
        bit fall, auto_s, tick, nh;
        int free;
        if (rst || !bus.start_game) begin
            for (int i = 0; i < NB; i++) begin
                ms[i].busy = 1'b0; ms[i].dir = 0; ms[i].x = 0; ms[i].y = 0;
            end
            m_delay = 0; m_step = 0; m_prev_key = 1'b0; m_pend = 1'b0;
            m_ovf = 1'b0; m_hit = 1'b0; m_done = '0;
        end else begin
            nh = 1'b0;
            for (int i = 0; i < NB; i++)
                if (ms[i].busy && boxes_meet(ms[i].x, ms[i].y, int'(bus.xpos_donkey),
                                             int'(bus.ypos_donkey))) nh = 1'b1;
            fall       = m_pend;
            m_pend     = bus.key_fall && !m_prev_key;
            m_prev_key = bus.key_fall;
            m_done     = '0;
            m_ovf      = 1'b0;
            if (!bus.animation) begin
                tick    = (m_step == STEPC - 1);
                m_step  = tick ? 0 : m_step + 1;
                auto_s  = (m_delay == DELAY - 1);
                m_delay = auto_s ? 0 : m_delay + 1;
                free    = -1;
                for (int i = 0; i < NB; i++) if (!ms[i].busy && free < 0) free = i;
                for (int i = 0; i < NB; i++) begin
                    if (!ms[i].busy) continue;
                    if (tick) begin
                        if (ms[i].dir == 1) begin
                            if (ms[i].x + STEPPX >= XMAX) begin
                                ms[i].x = XMAX; ms[i].y = sat(ms[i].y + DROP); ms[i].dir = -1;
                            end else ms[i].x = sat(ms[i].x + STEPPX);
                        end else if (ms[i].dir == -1) begin
                            if (ms[i].x <= STEPPX) begin
                                ms[i].x = 0; ms[i].y = sat(ms[i].y + DROP); ms[i].dir = 1;
                            end else ms[i].x = ms[i].x - STEPPX;
                        end else ms[i].y = sat(ms[i].y + STEPPX);
                    end else if (ms[i].y >= YMAX) begin
                        ms[i].busy = 1'b0;
                        m_done[i]  = 1'b1;
                    end
                end
                if (fall || auto_s) begin
                    if (free < 0) m_ovf = 1'b1;
                    else begin
                        ms[free].busy = 1'b1;
                        ms[free].dir  = fall ? 0 : 1;
                        ms[free].x    = fall ? int'(bus.xpos_kong) : SX;
                        ms[free].y    = fall ? 0 : SY;
                    end
                end
            end
            m_hit = nh;
        end
    endtask

    // One clock: model sees the same inputs as the DUT edge, outputs sampled at negedge.
    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) cycle();
    endtask

    task automatic restart();
        bus.start_game = 1'b1;
        cyc = 0;
    endtask

    task automatic chk_cleared(input string name);
        chk({name, ".active"}, 64'(bus.active), 64'd0);
        chk({name, ".pos"}, 64'({bus.xpos, bus.ypos}), 64'd0);
        chk({name, ".flags"}, 64'({bus.done, bus.overflow, bus.hit}), 64'd0);
    endtask

    typedef struct {
        int dx;
        int dy;
        bit hit;
    } hv_t;

    hv_t hv [10];

    logic [63:0] act_v, exp_v;

    initial begin
        hv[0] = '{176, 112, 1'b1}; hv[1] = '{192, 128, 1'b0};
        hv[2] = '{112, 128, 1'b0}; hv[3] = '{113, 128, 1'b1};
        hv[4] = '{160,  64, 1'b0}; hv[5] = '{160,  65, 1'b1};
        hv[6] = '{160, 160, 1'b0}; hv[7] = '{160, 159, 1'b1};
        hv[8] = '{  0,   0, 1'b0}; hv[9] = '{150, 100, 1'b1};

        rst = 1'b1;
        bus.start_game  = 1'b1;
        bus.animation   = 1'b0;
        bus.key_fall    = 1'b0;
        bus.xpos_kong   = 11'd512;
        bus.xpos_donkey = 11'd1500;
        bus.ypos_donkey = 11'd1500;
        @(negedge clk);
        repeat (3) cycle();
        chk_cleared("reset");
        rst = 1'b0;
        bus.start_game = 1'b0;
        cycle();

        // Auto spawn, turn-around, retire, reuse, key spawn, overflow.
        restart();
        goto(99);
        chk("no_spawn@99", 64'(bus.active), 64'd0);
        goto(100);
        chk("spawn0@100", 64'({bus.active, bus.xpos[0], bus.ypos[0]}), {40'd0, 2'b01, 11'd160, 11'd128});
        goto(104);
        chk("step1_x", 64'(bus.xpos[0]), 64'd168);
        goto(120);
        chk("turn_xy", 64'({bus.xpos[0], bus.ypos[0]}), {42'd0, 11'd200, 11'd224});
        goto(124);
        chk("left_step", 64'({bus.xpos[0], bus.ypos[0]}), {42'd0, 11'd192, 11'd224});
        chk("no_hit_far", 64'(bus.hit), 64'd0);
        goto(200);
        chk("spawn1@200", 64'({bus.active, bus.xpos[1], bus.ypos[1]}), {40'd0, 2'b11, 11'd160, 11'd128});
        goto(220);
        chk("drop2", 64'({bus.done, bus.xpos[0], bus.ypos[0]}), {40'd0, 2'b00, 11'd0, 11'd320});
        goto(221);
        chk("retire0", 64'({bus.done, bus.active, bus.xpos[0], bus.ypos[0]}),
            {38'd0, 2'b01, 2'b10, 11'd0, 11'd320});
        goto(222);
        chk("done_once", 64'(bus.done), 64'd0);
        goto(300);
        chk("reuse0", 64'({bus.active, bus.xpos[0], bus.ypos[0]}), {40'd0, 2'b11, 11'd160, 11'd128});
        goto(321);
        chk("retire1", 64'({bus.done, bus.active}), {60'd0, 2'b10, 2'b01});
        goto(329);
        bus.key_fall = 1'b1;
        goto(330);
        chk("key_latency", 64'(bus.active), 64'd1);
        goto(331);
        chk("fall1", 64'({bus.active, bus.xpos[1], bus.ypos[1]}), {40'd0, 2'b11, 11'd512, 11'd0});
        goto(335);
        bus.key_fall = 1'b0;
        goto(400);
        chk("overflow", 64'({bus.overflow, bus.active}), {61'd0, 1'b1, 2'b11});
        goto(401);
        chk("overflow_pulse", 64'(bus.overflow), 64'd0);
        goto(402);
        bus.start_game = 1'b0;
        cycle();
        chk_cleared("clear");

        // Collision table against a barrel frozen at the spawn point.
        restart();
        goto(100);
        bus.animation = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.xpos_donkey = 11'(hv[k].dx);
            bus.ypos_donkey = 11'(hv[k].dy);
            cycle();
            chk($sformatf("hit_vec%0d", k), 64'(bus.hit), 64'(hv[k].hit));
        end
        bus.xpos_donkey = 11'd1500;
        bus.ypos_donkey = 11'd1500;
        goto(cyc + 150);
        chk("frozen", 64'({bus.active, bus.xpos[0], bus.ypos[0]}), {40'd0, 2'b01, 11'd160, 11'd128});
        bus.animation  = 1'b0;
        bus.start_game = 1'b0;
        cycle();
        chk_cleared("clear2");

        // Key spawn issued in the same cycle the auto timer expires.
        restart();
        goto(98);
        bus.key_fall = 1'b1;
        goto(100);
        chk("prio", 64'({bus.overflow, bus.active, bus.xpos[0], bus.ypos[0]}),
            {39'd0, 1'b0, 2'b01, 11'd512, 11'd0});
        goto(101);
        chk("prio_dropped", 64'({bus.overflow, bus.active}), {61'd0, 1'b0, 2'b01});
        bus.key_fall = 1'b0;

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            bus.start_game = ($urandom_range(0, 599) != 0);
            if (bus.animation) bus.animation = ($urandom_range(0, 9) != 0);
            else bus.animation = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 39) == 0) bus.key_fall = ~bus.key_fall;
            bus.xpos_kong = 11'($urandom_range(0, 2047));
            if ((n % 16) == 0) begin
                bus.xpos_donkey = 11'($urandom_range(0, 600));
                bus.ypos_donkey = 11'($urandom_range(0, 400));
            end
            cycle();
            act_v = {14'd0, bus.hit, bus.overflow, bus.done, bus.ypos, bus.xpos, bus.active};
            exp_v = {14'd0, m_hit, m_ovf, m_done, 11'(ms[1].y), 11'(ms[0].y),
                     11'(ms[1].x), 11'(ms[0].x), ms[1].busy, ms[0].busy};
            chk($sformatf("rand%0d", n), act_v, exp_v);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
